// File: rtl/fifo_ctrl_pkg.sv
// fifo_ctrl_pkg: state encoding, clog2 helper and FIFO constants shared by the FIFO write path.
package fifo_ctrl_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_BURST = 1'b1} state_t;
  localparam int DATA_W_DEF = 4;
  localparam int FIFO_DEPTH = 16;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/fifo_rr_write_arbiter_rr_pick.sv
// rr_pick: rotate-priority picker, first requester after last in circular order.
module rr_pick import fifo_ctrl_pkg::*; #(
  parameter int N = 4,
  localparam int W = clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [W-1:0] grant,
  output logic         any
);
  // Scanning from the far end lets the nearest requester win.
  always_comb begin
    grant = '0;
    for (int k = N; k >= 1; k--)
      if (req[(int'(last) + k) % N]) grant = W'((int'(last) + k) % N);
  end
  assign any = |req;
endmodule

// File: rtl/fifo_rr_write_arbiter.sv
// fifo_rr_write_arbiter: round-robin burst arbitration of N_REQ producers onto one FIFO write port.
module fifo_rr_write_arbiter import fifo_ctrl_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int DATA_W = DATA_W_DEF,
  parameter int MAX_BURST = 4,
  localparam int OW = clog2(N_REQ),
  localparam int CW = clog2(MAX_BURST + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        ack,
  input  logic                    fifo_full,
  output logic                    fifo_write_enb,
  output logic [DATA_W-1:0]       fifo_datain,
  output logic [OW-1:0]           owner,
  output logic                    busy
);
  state_t state, state_nxt;
  logic [OW-1:0] last_owner, pick;
  logic [CW-1:0] burst_cnt;
  logic any, wr, last_word;
  rr_pick #(.N(N_REQ)) u_pick (.req(req), .last(last_owner), .grant(pick), .any(any));
  assign busy = state == ST_BURST;
  assign wr = busy & req[owner] & ~fifo_full;
  assign last_word = burst_cnt == CW'(MAX_BURST - 1);
  assign fifo_write_enb = wr;
  assign ack = wr ? N_REQ'(1) << owner : '0;
  assign fifo_datain = busy ? req_data[int'(owner)*DATA_W +: DATA_W] : '0;
  // A full stall keeps the grant; only a dropped request or the last word ends it.
  always_comb begin
    state_nxt = state;
    state_nxt = busy ? ((!req[owner] || (wr && last_word)) ? ST_IDLE : ST_BURST)
                     : (any ? ST_BURST : ST_IDLE);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= ST_IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      owner <= '0;
      last_owner <= OW'(N_REQ - 1);
      burst_cnt <= '0;
    end else if (!busy) begin
      burst_cnt <= '0;
      if (any) owner <= pick;
    end else begin
      if (state_nxt == ST_IDLE) last_owner <= owner;
      if (wr) burst_cnt <= last_word ? '0 : burst_cnt + CW'(1);
    end
endmodule

// File: tb/tb_fifo_rr_write_arbiter.sv
// tb_fifo_rr_write_arbiter: directed checks of arbitration, bursts, stalls, reset and FIFO integration.
module tb_fifo_rr_write_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req_dir = '0, req_auto, req, ack;
  logic [15:0] data_dir = '0, data_auto, req_data;
  logic full_dir = 1'b0, fifo_full, fifo_write_enb, busy, use_model = 1'b0;
  logic [3:0] fifo_datain;
  logic [1:0] owner;
  int n_run = 0, n_fail = 0;
  int ptr [3] = '{0, 0, 0};
  int cnt_w [3] = '{7, 7, 6};
  int cyc = 0, fcnt = 0, ovf = 0, stalls = 0;
  logic we_s = 1'b0;
  logic [3:0] din_s = '0, ack_s = '0;
  logic [3:0] fq [$];
  logic [3:0] rq [$];
  logic [3:0] exp6 [20];

  fifo_rr_write_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
    .fifo_full(fifo_full), .fifo_write_enb(fifo_write_enb), .fifo_datain(fifo_datain),
    .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  assign req = use_model ? req_auto : req_dir;
  assign req_data = use_model ? data_auto : data_dir;
  assign fifo_full = use_model ? (fcnt == 16) : full_dir;

  always_comb begin
    req_auto = '0;
    data_auto = '0;
    for (int i = 0; i < 3; i++) begin
      req_auto[i] = ptr[i] < cnt_w[i];
      data_auto[i*4 +: 4] = 4'((i * 7 + ptr[i]) & 15);
    end
  end

  always @(negedge clk) begin
    we_s <= fifo_write_enb;
    din_s <= fifo_datain;
    ack_s <= ack;
    if (use_model && busy && req[owner] && fifo_full) stalls <= stalls + 1;
  end

  // Producer and 16-deep FIFO model; reader starts late so the FIFO fills up.
  always @(posedge clk) begin
    if (!use_model) begin
      ptr <= '{0, 0, 0};
      cyc <= 0;
      fcnt <= 0;
      fq.delete();
      rq.delete();
    end else begin
      cyc <= cyc + 1;
      for (int i = 0; i < 3; i++) if (ack_s[i]) ptr[i] <= ptr[i] + 1;
      if (we_s) begin
        if (fcnt >= 16) ovf <= ovf + 1;
        else fq.push_back(din_s);
      end
      if (cyc >= 30 && cyc % 2 == 0 && fcnt > 0) rq.push_back(fq.pop_front());
      fcnt <= fq.size();
    end
  end

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] w4 [4];
    logic [3:0] rq5, we5, bz5;
    int k, o, idx;
    // 1: reset values, async reset mid-burst, first grant after release
    go(); #2;
    chk("rst_ack", ack, 0);
    chk("rst_we", fifo_write_enb, 0);
    chk("rst_din", fifo_datain, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    rst = 1'b0;
    go(); req_dir = 4'b0110; data_dir = 16'h4321; #2;
    chk("t1_idle_we", fifo_write_enb, 0);
    go(); #2;
    chk("t1_owner", owner, 1);
    chk("t1_ack", ack, 4'b0010);
    chk("t1_din", fifo_datain, 2);
    rst = 1'b1; #1;
    chk("t1_async_ack", ack, 0);
    chk("t1_async_we", fifo_write_enb, 0);
    chk("t1_async_busy", busy, 0);
    go(); rst = 1'b0; req_dir = 4'b1100; #2;
    chk("t1_rel_busy", busy, 0);
    go(); #2;
    chk("t1_first_owner", owner, 2);
    chk("t1_first_we", fifo_write_enb, 1);
    chk("t1_first_din", fifo_datain, 3);
    req_dir = '0;
    go(); go(); #2;
    chk("t1_end_busy", busy, 0);
    // 2: single producer on index 2 with 6 words
    k = 0;
    for (int c = 0; c < 8; c++) begin
      logic [7:0] pat;
      pat = 8'b11011110;
      go();
      req_dir = (k < 6) ? 4'b0100 : 4'b0000;
      data_dir = {4'h0, 4'(4'hA + k), 8'h00};
      #2;
      chk($sformatf("t2_we_c%0d", c), fifo_write_enb, pat[c]);
      chk($sformatf("t2_ack_c%0d", c), ack, pat[c] ? 4'b0100 : 4'b0000);
      if (pat[c]) begin
        chk($sformatf("t2_din_c%0d", c), fifo_datain, 4'hA + k);
        k++;
      end
    end
    go(); req_dir = '0; #2;
    chk("t2_drop_we", fifo_write_enb, 0);
    go(); #2;
    chk("t2_drop_busy", busy, 0);
    // 3: all four requesting, owner order 0,1,2,3,0 with 4 words each
    go(); rst = 1'b1; go(); rst = 1'b0;
    for (int c = 0; c < 25; c++) begin
      go(); req_dir = 4'b1111; data_dir = 16'h4321; #2;
      o = (c / 5) % 4;
      if (c % 5 == 0) begin
        chk($sformatf("t3_idle_c%0d", c), fifo_write_enb, 0);
        chk($sformatf("t3_busy_c%0d", c), busy, 0);
      end else begin
        chk($sformatf("t3_owner_c%0d", c), owner, o);
        chk($sformatf("t3_ack_c%0d", c), ack, 4'b0001 << o);
        chk($sformatf("t3_din_c%0d", c), fifo_datain, o + 1);
      end
    end
    go(); req_dir = '0; #2;
    chk("t3_end_busy", busy, 0);
    // 4: three full cycles mid-burst on producer 1
    w4 = '{4'h9, 4'hA, 4'hB, 4'hC};
    k = 0;
    for (int c = 0; c < 8; c++) begin
      logic [7:0] pat;
      pat = 8'b11000110;
      go();
      req_dir = (k < 4) ? 4'b0010 : 4'b0000;
      data_dir = {8'h00, (k < 4) ? w4[k] : 4'h0, 4'h0};
      full_dir = c >= 3 && c <= 5;
      #2;
      chk($sformatf("t4_we_c%0d", c), fifo_write_enb, pat[c]);
      chk($sformatf("t4_ack_c%0d", c), ack, pat[c] ? 4'b0010 : 4'b0000);
      chk($sformatf("t4_busy_c%0d", c), busy, c >= 1);
      if (c >= 1) chk($sformatf("t4_din_c%0d", c), fifo_datain, w4[k]);
      if (pat[c]) k++;
    end
    go(); req_dir = '0; full_dir = 1'b0; #2;
    chk("t4_end_busy", busy, 0);
    chk("t4_end_we", fifo_write_enb, 0);
    // 5: owner 2 drops after 2 words, then producer 3 gets a full 4-word burst
    for (int c = 0; c < 10; c++) begin
      logic [9:0] we_pat, busy_pat;
      we_pat = 10'b0111100110;
      busy_pat = 10'b0111101110;
      go();
      req_dir = c < 3 ? 4'b1100 : (c < 9 ? 4'b1000 : 4'b0000);
      data_dir = 16'h6500;
      #2;
      chk($sformatf("t5_we_c%0d", c), fifo_write_enb, we_pat[c]);
      chk($sformatf("t5_busy_c%0d", c), busy, busy_pat[c]);
      if (busy_pat[c]) chk($sformatf("t5_owner_c%0d", c), owner, c <= 3 ? 2 : 3);
      if (we_pat[c]) chk($sformatf("t5_din_c%0d", c), fifo_datain, c <= 3 ? 5 : 6);
    end
    // 6: three producers, 20 words through the FIFO model
    idx = 0;
    for (int b = 0; b < 6; b++) begin
      int p, k0, n;
      p = b % 3;
      k0 = b < 3 ? 0 : 4;
      n = b < 3 ? 4 : cnt_w[p] - 4;
      for (int j = 0; j < n; j++) begin
        exp6[idx] = 4'((p * 7 + k0 + j) & 15);
        idx++;
      end
    end
    go(); rst = 1'b1; go(); rst = 1'b0; use_model = 1'b1;
    for (int i = 0; i < 400 && rq.size() < 20; i++) @(posedge clk);
    #3;
    chk("t6_read_count", rq.size(), 20);
    for (int i = 0; i < 20; i++)
      chk($sformatf("t6_rd%0d", i), i < rq.size() ? rq[i] : 4'hx, exp6[i]);
    chk("t6_overflow", ovf, 0);
    chk("t6_stalled", stalls > 0, 1);
    chk("t6_fifo_empty", fcnt, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
